// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access sizes and RV32I funct3 codes.
package lsu_pkg;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // The low two funct3 bits encode the access size for both loads and stores.
  function automatic lsu_size_t f3ToSize(input logic [1:0] f3Lo);
    case (f3Lo)
      2'b00:   return SZ_B;
      2'b01:   return SZ_H;
      default: return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store strobes/replication and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_off,
  input  lsu_size_t   st_size,
  input  logic [31:0] st_data,
  output logic [3:0]  st_strb,
  output logic [31:0] st_lanes,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_funct3,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [31:0] ldShifted;

  always_comb begin
    st_strb  = 4'b1111;
    st_lanes = st_data;
    case (st_size)
      SZ_B: begin
        st_strb  = 4'b0001 << st_off;
        st_lanes = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_strb  = 4'b0011 << {st_off[1], 1'b0};
        st_lanes = {2{st_data[15:0]}};
      end
      default: begin
        st_strb  = 4'b1111;
        st_lanes = st_data;
      end
    endcase
  end

  // Shift the addressed byte/half down to bit 0, then extend by funct3.
  always_comb begin
    ldShifted = ld_word >> {ld_off, 3'b000};
    case (ld_funct3)
      F3_B:    ld_data = {{24{ldShifted[7]}}, ldShifted[7:0]};
      F3_H:    ld_data = {{16{ldShifted[15]}}, ldShifted[15:0]};
      F3_BU:   ld_data = {24'h0, ldShifted[7:0]};
      F3_HU:   ld_data = {16'h0, ldShifted[15:0]};
      default: ld_data = ldShifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// RV32I load/store unit: one outstanding access over a valid/ready memory port.
// Define LSU_MISALIGN_TRAP_EN to fault misaligned accesses instead of force-aligning them.
module lsu
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
  output logic              resp_valid,
  output logic [4:0]        resp_rd,
  output logic [31:0]       resp_data,
  output logic              resp_err
);

  lsu_state_t        state_q, state_d;
  logic              ready_q, ready_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic              memValid_q, memValid_d;
  logic              memWe_q, memWe_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [3:0]        memStrb_q, memStrb_d;
  logic [31:0]       memWdata_q, memWdata_d;
  logic              respValid_q, respValid_d;
  logic [4:0]        respRd_q, respRd_d;
  logic [31:0]       respData_q, respData_d;
  logic              respErr_q, respErr_d;

  lsu_size_t   reqSize;
  logic        legal;
  logic        fault;
  logic [1:0]  alignedOff;
  logic [3:0]  stStrb;
  logic [31:0] stLanes;
  logic [31:0] ldData;

  always_comb begin
    reqSize = f3ToSize(req_funct3[1:0]);
    legal   = (req_funct3 == F3_B) || (req_funct3 == F3_H) || (req_funct3 == F3_W) ||
              (!req_we && ((req_funct3 == F3_BU) || (req_funct3 == F3_HU)));
    case (reqSize)
      SZ_B:    alignedOff = req_addr[1:0];
      SZ_H:    alignedOff = {req_addr[1], 1'b0};
      default: alignedOff = 2'b00;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    fault = !legal || ((reqSize == SZ_H) && req_addr[0]) ||
            ((reqSize == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    fault = !legal;
`endif
  end

  lsu_align u_align (
    .st_off    (alignedOff),
    .st_size   (reqSize),
    .st_data   (req_wdata),
    .st_strb   (stStrb),
    .st_lanes  (stLanes),
    .ld_off    (off_q),
    .ld_funct3 (f3_q),
    .ld_word   (mem_rdata),
    .ld_data   (ldData)
  );

  // Every output is a flop, so all output next-values are computed here from inputs and state.
  always_comb begin
    state_d     = state_q;
    ready_d     = 1'b0;
    we_d        = we_q;
    f3_d        = f3_q;
    off_d       = off_q;
    rd_d        = rd_q;
    memValid_d  = memValid_q;
    memWe_d     = memWe_q;
    memAddr_d   = memAddr_q;
    memStrb_d   = memStrb_q;
    memWdata_d  = memWdata_q;
    respValid_d = 1'b0;
    respErr_d   = 1'b0;
    respRd_d    = respRd_q;
    respData_d  = respData_q;
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (ready_q && req_valid) begin
          ready_d = 1'b0;
          we_d    = req_we;
          f3_d    = req_funct3;
          off_d   = alignedOff;
          rd_d    = req_rd;
          if (fault) begin
            state_d     = RESP;
            respValid_d = 1'b1;
            respErr_d   = 1'b1;
            respData_d  = 32'h0;
            respRd_d    = req_we ? 5'd0 : req_rd;
          end else begin
            state_d    = REQ;
            memValid_d = 1'b1;
            memWe_d    = req_we;
            memAddr_d  = {req_addr[ADDR_W-1:2], 2'b00};
            memStrb_d  = req_we ? stStrb : 4'b0000;
            memWdata_d = req_we ? stLanes : 32'h0;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          memValid_d = 1'b0;
          memWe_d    = 1'b0;
          memStrb_d  = 4'b0000;
          if (we_q) begin
            state_d     = RESP;
            respValid_d = 1'b1;
            respData_d  = 32'h0;
            respRd_d    = 5'd0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d     = RESP;
          respValid_d = 1'b1;
          respData_d  = ldData;
          respRd_d    = rd_q;
        end
      end
      RESP: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      we_q        <= 1'b0;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      rd_q        <= 5'd0;
      memValid_q  <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memStrb_q   <= 4'b0000;
      memWdata_q  <= 32'h0;
      respValid_q <= 1'b0;
      respRd_q    <= 5'd0;
      respData_q  <= 32'h0;
      respErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      we_q        <= we_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      rd_q        <= rd_d;
      memValid_q  <= memValid_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memStrb_q   <= memStrb_d;
      memWdata_q  <= memWdata_d;
      respValid_q <= respValid_d;
      respRd_q    <= respRd_d;
      respData_q  <= respData_d;
      respErr_q   <= respErr_d;
    end
  end

  assign req_ready  = ready_q;
  assign mem_valid  = memValid_q;
  assign mem_we     = memWe_q;
  assign mem_addr   = memAddr_q;
  assign mem_wstrb  = memStrb_q;
  assign mem_wdata  = memWdata_q;
  assign resp_valid = respValid_q;
  assign resp_rd    = respRd_q;
  assign resp_data  = respData_q;
  assign resp_err   = respErr_q;

endmodule

// File: tb/tb_lsu.sv
// Directed, table-driven bench for lsu; expectations follow LSU_MISALIGN_TRAP_EN when defined.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_err;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          stall;
    int          rvDelay;
    logic        expErr;
    logic [31:0] expAddr;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
    logic [31:0] expData;
    logic [4:0]  expRd;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  lsu #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_rd     (req_rd),
    .mem_valid  (mem_valid),
    .mem_ready  (mem_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wstrb  (mem_wstrb),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .resp_valid (resp_valid),
    .resp_rd    (resp_rd),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [4:0] rd, input logic [31:0] rdata, input int stall,
                              input int rvDelay, input logic expErr, input logic [31:0] expAddr,
                              input logic [3:0] expStrb, input logic [31:0] expWdata,
                              input logic [31:0] expData, input logic [4:0] expRd,
                              input int expLat);
    vec_t v;
    v.name = name; v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
    v.rdata = rdata; v.stall = stall; v.rvDelay = rvDelay; v.expErr = expErr;
    v.expAddr = expAddr; v.expStrb = expStrb; v.expWdata = expWdata; v.expData = expData;
    v.expRd = expRd; v.expLat = expLat;
    return v;
  endfunction

  task automatic idleInputs();
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b111;
    req_addr   = 32'hFFFF_FFFF;
    req_wdata  = 32'h0;
    req_rd     = 5'd31;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'hDEAD_BEEF;
  endtask

  // Issue one request, act as the memory model, and check every observable of the transaction.
  task automatic applyStimulus(input vec_t v);
    int n;
    int lat;
    int rvCycle;
    int stallLeft;
    logic seen, stable, gotResp, errAt, readyAtResp;
    logic [31:0] a0, w0, dataAt;
    logic [3:0] s0;
    logic we0;
    logic [4:0] rdAt;
    n = 0;
    while (!req_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput({v.name, ".req_ready"}, {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3; req_addr = v.addr;
    req_wdata = v.wdata; req_rd = v.rd;
    @(posedge clk); #1;
    idleInputs();
    seen = 0; stable = 1; gotResp = 0; lat = 0; rvCycle = -1; stallLeft = v.stall;
    errAt = 0; dataAt = 0; rdAt = 0; readyAtResp = 0;
    a0 = 0; w0 = 0; s0 = 0; we0 = 0;
    for (int c = 1; c <= 30 && !gotResp; c++) begin
      mem_rvalid = (c == rvCycle);
      mem_rdata  = (c == rvCycle) ? v.rdata : 32'hDEAD_BEEF;
      mem_ready  = 1'b0;
      if (mem_valid) begin
        if (!seen) begin
          seen = 1; a0 = mem_addr; s0 = mem_wstrb; w0 = mem_wdata; we0 = mem_we;
        end else if (mem_addr !== a0 || mem_wstrb !== s0 || mem_wdata !== w0 || mem_we !== we0) begin
          stable = 0;
        end
        if (stallLeft > 0) stallLeft--;
        else begin
          mem_ready = 1'b1;
          if (!mem_we) rvCycle = c + 1 + v.rvDelay;
        end
      end
      if (resp_valid) begin
        gotResp = 1; lat = c; errAt = resp_err; dataAt = resp_data; rdAt = resp_rd;
        readyAtResp = req_ready;
      end else begin
        @(posedge clk); #1;
      end
    end
    idleInputs();
    checkOutput({v.name, ".latency"}, lat, v.expLat);
    checkOutput({v.name, ".resp_err"}, {31'h0, errAt}, {31'h0, v.expErr});
    checkOutput({v.name, ".resp_data"}, dataAt, v.expData);
    checkOutput({v.name, ".resp_rd"}, {27'h0, rdAt}, {27'h0, v.expRd});
    checkOutput({v.name, ".ready_in_resp"}, {31'h0, readyAtResp}, 32'd0);
    checkOutput({v.name, ".mem_used"}, {31'h0, seen}, {31'h0, !v.expErr});
    if (!v.expErr) begin
      checkOutput({v.name, ".mem_addr"}, a0, v.expAddr);
      checkOutput({v.name, ".mem_wstrb"}, {28'h0, s0}, {28'h0, v.expStrb});
      checkOutput({v.name, ".mem_we"}, {31'h0, we0}, {31'h0, v.we});
      checkOutput({v.name, ".mem_stable"}, {31'h0, stable}, 32'd1);
      if (v.we) checkOutput({v.name, ".mem_wdata"}, w0, v.expWdata);
    end
    @(posedge clk); #1;
    checkOutput({v.name, ".resp_pulse"}, {31'h0, resp_valid}, 32'd0);
    checkOutput({v.name, ".ready_after"}, {31'h0, req_ready}, 32'd1);
  endtask

  task automatic watchQuiet(input string name, input int cycles);
    logic sawResp, sawMem;
    sawResp = 0; sawMem = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (resp_valid) sawResp = 1;
      if (mem_valid) sawMem = 1;
    end
    checkOutput({name, ".no_resp"}, {31'h0, sawResp}, 32'd0);
    checkOutput({name, ".no_mem"}, {31'h0, sawMem}, 32'd0);
    checkOutput({name, ".req_ready"}, {31'h0, req_ready}, 32'd1);
  endtask

  initial begin
    idleInputs();
    rst = 1'b1;

    vecs.push_back(mk("sb_1003", 1, 3'b000, 32'h1003, 32'h0000_00A5, 5'd7, 32'h0, 0, 0,
                      0, 32'h1000, 4'b1000, 32'hA5A5_A5A5, 32'h0, 5'd0, 2));
    vecs.push_back(mk("lb_2002", 0, 3'b000, 32'h2002, 32'h0, 5'd5, 32'h0080_FF00, 0, 0,
                      0, 32'h2000, 4'b0000, 32'h0, 32'hFFFF_FF80, 5'd5, 3));
    vecs.push_back(mk("lbu_2002", 0, 3'b100, 32'h2002, 32'h0, 5'd6, 32'h0080_FF00, 0, 0,
                      0, 32'h2000, 4'b0000, 32'h0, 32'h0000_0080, 5'd6, 3));
    vecs.push_back(mk("lh_2002", 0, 3'b001, 32'h2002, 32'h0, 5'd8, 32'h8001_1234, 0, 0,
                      0, 32'h2000, 4'b0000, 32'h0, 32'hFFFF_8001, 5'd8, 3));
    vecs.push_back(mk("lh_stall3", 0, 3'b001, 32'h2002, 32'h0, 5'd8, 32'h8001_1234, 3, 0,
                      0, 32'h2000, 4'b0000, 32'h0, 32'hFFFF_8001, 5'd8, 6));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mk("lw_3001", 0, 3'b010, 32'h3001, 32'h0, 5'd9, 32'hCAFE_F00D, 0, 0,
                      1, 32'h0, 4'b0000, 32'h0, 32'h0, 5'd9, 1));
    vecs.push_back(mk("sh_1001", 1, 3'b001, 32'h1001, 32'h0000_CAFE, 5'd4, 32'h0, 0, 0,
                      1, 32'h0, 4'b0000, 32'h0, 32'h0, 5'd0, 1));
`else
    vecs.push_back(mk("lw_3001", 0, 3'b010, 32'h3001, 32'h0, 5'd9, 32'hCAFE_F00D, 0, 0,
                      0, 32'h3000, 4'b0000, 32'h0, 32'hCAFE_F00D, 5'd9, 3));
    vecs.push_back(mk("sh_1001", 1, 3'b001, 32'h1001, 32'h0000_CAFE, 5'd4, 32'h0, 0, 0,
                      0, 32'h1000, 4'b0011, 32'hCAFE_CAFE, 32'h0, 5'd0, 2));
`endif
    vecs.push_back(mk("ld_f3_011", 0, 3'b011, 32'h4000, 32'h0, 5'd10, 32'h1111_1111, 0, 0,
                      1, 32'h0, 4'b0000, 32'h0, 32'h0, 5'd10, 1));
    vecs.push_back(mk("sh_1006", 1, 3'b001, 32'h1006, 32'h1234_BEEF, 5'd3, 32'h0, 0, 0,
                      0, 32'h1004, 4'b1100, 32'hBEEF_BEEF, 32'h0, 5'd0, 2));
    vecs.push_back(mk("sw_stall1", 1, 3'b010, 32'h1008, 32'h1122_3344, 5'd2, 32'h0, 1, 0,
                      0, 32'h1008, 4'b1111, 32'h1122_3344, 32'h0, 5'd0, 3));
    vecs.push_back(mk("lhu_2000", 0, 3'b101, 32'h2000, 32'h0, 5'd11, 32'h1234_F00D, 0, 0,
                      0, 32'h2000, 4'b0000, 32'h0, 32'h0000_F00D, 5'd11, 3));
    vecs.push_back(mk("lh_2000", 0, 3'b001, 32'h2000, 32'h0, 5'd12, 32'h1234_F00D, 0, 0,
                      0, 32'h2000, 4'b0000, 32'h0, 32'hFFFF_F00D, 5'd12, 3));
    vecs.push_back(mk("lb_2001", 0, 3'b000, 32'h2001, 32'h0, 5'd13, 32'h1234_7F56, 0, 0,
                      0, 32'h2000, 4'b0000, 32'h0, 32'h0000_007F, 5'd13, 3));
    vecs.push_back(mk("st_f3_011", 1, 3'b011, 32'h1000, 32'h5555_5555, 5'd1, 32'h0, 0, 0,
                      1, 32'h0, 4'b0000, 32'h0, 32'h0, 5'd0, 1));
    vecs.push_back(mk("st_f3_100", 1, 3'b100, 32'h1000, 32'h5555_5555, 5'd1, 32'h0, 0, 0,
                      1, 32'h0, 4'b0000, 32'h0, 32'h0, 5'd0, 1));
    vecs.push_back(mk("lw_rvdly2", 0, 3'b010, 32'h5000, 32'h0, 5'd14, 32'h89AB_CDEF, 0, 2,
                      0, 32'h5000, 4'b0000, 32'h0, 32'h89AB_CDEF, 5'd14, 5));
    vecs.push_back(mk("lbu_2003", 0, 3'b100, 32'h2003, 32'h0, 5'd15, 32'h9A00_0000, 0, 0,
                      0, 32'h2000, 4'b0000, 32'h0, 32'h0000_009A, 5'd15, 3));

    // Reset values while reset is held, then ready after release.
    #12;
    checkOutput("rst.req_ready", {31'h0, req_ready}, 32'd0);
    checkOutput("rst.mem_valid", {31'h0, mem_valid}, 32'd0);
    checkOutput("rst.mem_we", {31'h0, mem_we}, 32'd0);
    checkOutput("rst.mem_wstrb", {28'h0, mem_wstrb}, 32'd0);
    checkOutput("rst.mem_addr", mem_addr, 32'd0);
    checkOutput("rst.mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst.resp_valid", {31'h0, resp_valid}, 32'd0);
    checkOutput("rst.resp_err", {31'h0, resp_err}, 32'd0);
    checkOutput("rst.resp_data", resp_data, 32'd0);
    checkOutput("rst.resp_rd", {27'h0, resp_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst.ready_after_release", {31'h0, req_ready}, 32'd1);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Reset while REQ is stalled: mem_valid must fall without waiting for a clock edge.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h6000; req_rd = 5'd20;
    @(posedge clk); #1;
    idleInputs();
    checkOutput("rstreq.mem_valid_before", {31'h0, mem_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstreq.mem_valid_async", {31'h0, mem_valid}, 32'd0);
    checkOutput("rstreq.req_ready_in_rst", {31'h0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    watchQuiet("rstreq", 5);

    // Reset while in WAIT, then a stale read return after release.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h7004; req_rd = 5'd21;
    @(posedge clk); #1;
    idleInputs();
    mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    watchQuiet("rstwait", 4);
    applyStimulus(vecs[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
